// File: rtl/multicycle_ctrl_if.sv
// Signal bundle between the multicycle controller and the KGP-RISC
// datapath / memory: decoded IR fields and status in, enables and selects out.
interface multicycle_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [5:0]       opcode;
   logic [4:0]       funct;
   logic             mem_ready;
   logic             branch_cond;
   logic             memRead;
   logic             memWrite;
   logic             irWrite;
   logic             pcWrite;
   logic             pcSrc;
   logic             regWrite;
   logic             memToReg;
   logic             aluSrcB;
   logic             ALUOp;
   logic [4:0]       funcCode;
   logic [2:0]       state;
   logic             halted;
   logic             fault;
   logic             illegal;
   logic [CNT_W-1:0] instCount;

   modport master (
      input  opcode, funct, mem_ready, branch_cond,
      output memRead, memWrite, irWrite, pcWrite, pcSrc,
      output regWrite, memToReg, aluSrcB, ALUOp, funcCode,
      output state, halted, fault, illegal, instCount
   );

   modport slave (
      output opcode, funct, mem_ready, branch_cond,
      input  memRead, memWrite, irWrite, pcWrite, pcSrc,
      input  regWrite, memToReg, aluSrcB, ALUOp, funcCode,
      input  state, halted, fault, illegal, instCount
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// KGP-RISC multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory wait timeout, sticky fault/illegal flags and retired-instruction count.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input logic         clk,
   input logic         reset,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [5:0] OP_R    = 6'd0;
   localparam logic [5:0] OP_I    = 6'd1;
   localparam logic [5:0] OP_LW   = 6'd2;
   localparam logic [5:0] OP_SW   = 6'd3;
   localparam logic [5:0] OP_BR   = 6'd4;
   localparam logic [5:0] OP_HALT = 6'd5;
   localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);

   state_t           st;
   logic [5:0]       op_q;
   logic [4:0]       fn_q;
   logic [7:0]       wait_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fault_q;
   logic             illegal_q;

   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       pc_write;
   logic       pc_src;
   logic       reg_write;
   logic       mem_to_reg;
   logic       alu_src_b;
   logic       alu_op;
   logic [4:0] func_code;

   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= FETCH;
         op_q      <= '0;
         fn_q      <= '0;
         wait_q    <= '0;
         cnt_q     <= '0;
         fault_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         // Outside the two waiting states the counter idles at zero, so
         // every entry into FETCH or MEM starts a fresh timeout window.
         if (st != FETCH && st != MEM)
            wait_q <= '0;
         case (st)
            FETCH, MEM: begin
               if (bus.mem_ready) begin
                  wait_q <= '0;
                  if (st == FETCH) begin
                     st <= DECODE;
                  end else if (op_q == OP_LW) begin
                     st <= WB;
                  end else begin
                     st    <= FETCH;
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end else if (wait_q >= TMO) begin
                  st      <= HALT;
                  fault_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            DECODE: begin
               if (bus.opcode <= OP_BR) begin
                  st   <= EXEC;
                  op_q <= bus.opcode;
                  fn_q <= bus.funct;
               end else if (bus.opcode == OP_HALT) begin
                  st <= HALT;
               end else begin
                  st        <= HALT;
                  illegal_q <= 1'b1;
               end
            end
            EXEC: begin
               case (op_q)
                  OP_LW, OP_SW: st <= MEM;
                  OP_BR: begin
                     st    <= FETCH;
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
                  default: st <= WB;
               endcase
            end
            WB: begin
               st    <= FETCH;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            HALT: st <= HALT;
            default: begin
               st        <= HALT;
               illegal_q <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = 1'b0;
      func_code  = '0;
      case (st)
         FETCH: begin
            mem_read = 1'b1;
            ir_write = bus.mem_ready;
            pc_write = bus.mem_ready;
         end
         EXEC: begin
            case (op_q)
               OP_R: begin
                  alu_op    = 1'b1;
                  func_code = fn_q;
               end
               OP_I: begin
                  alu_op    = 1'b1;
                  func_code = fn_q;
                  alu_src_b = 1'b1;
               end
               OP_LW, OP_SW: alu_src_b = 1'b1;
               OP_BR: begin
                  pc_src   = 1'b1;
                  pc_write = bus.branch_cond;
               end
               default: ;
            endcase
         end
         MEM: begin
            mem_read  = (op_q == OP_LW);
            mem_write = (op_q == OP_SW);
         end
         WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (op_q == OP_LW);
         end
         default: ;
      endcase
      // State-changing writes must never escape while reset is held.
      if (reset) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
      end
   end

   assign bus.memRead   = mem_read;
   assign bus.memWrite  = mem_write;
   assign bus.irWrite   = ir_write;
   assign bus.pcWrite   = pc_write;
   assign bus.pcSrc     = pc_src;
   assign bus.regWrite  = reg_write;
   assign bus.memToReg  = mem_to_reg;
   assign bus.aluSrcB   = alu_src_b;
   assign bus.ALUOp     = alu_op;
   assign bus.funcCode  = func_code;
   assign bus.state     = st;
   assign bus.halted    = (st == HALT);
   assign bus.fault     = fault_q;
   assign bus.illegal   = illegal_q;
   assign bus.instCount = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed per-cycle vector bench for multicycle_ctrl, plus hand sequences
// for counter wrap (CNT_W = 2) and a MEM-stage timeout.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [4:0] funct;
   logic       mem_ready;
   logic       branch_cond;

   always #5 clk = ~clk;

   multicycle_ctrl_if #(.CNT_W(16)) b1 ();
   multicycle_ctrl_if #(.CNT_W(2))  b2 ();

   assign b1.opcode      = opcode;
   assign b1.funct       = funct;
   assign b1.mem_ready   = mem_ready;
   assign b1.branch_cond = branch_cond;
   assign b2.opcode      = opcode;
   assign b2.funct       = funct;
   assign b2.mem_ready   = mem_ready;
   assign b2.branch_cond = branch_cond;

   multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b1)
   );

   multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (b2)
   );

   // enable order: memRead memWrite irWrite pcWrite pcSrc regWrite memToReg aluSrcB ALUOp
   localparam logic [8:0] E0   = 9'b000000000;
   localparam logic [8:0] E_FR = 9'b101100000;
   localparam logic [8:0] E_FW = 9'b100000000;
   localparam logic [8:0] E_R  = 9'b000000001;
   localparam logic [8:0] E_I  = 9'b000000011;
   localparam logic [8:0] E_LS = 9'b000000010;
   localparam logic [8:0] E_BT = 9'b000110000;
   localparam logic [8:0] E_BN = 9'b000010000;
   localparam logic [8:0] E_MR = 9'b100000000;
   localparam logic [8:0] E_MW = 9'b010000000;
   localparam logic [8:0] E_WB = 9'b000001000;
   localparam logic [8:0] E_WL = 9'b000001100;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [4:0]  fn;
      logic        rdy;
      logic        bc;
      logic [2:0]  st;
      logic [8:0]  en;
      logic [4:0]  fc;
      logic [2:0]  fl;
      logic [15:0] cnt;
   } vec_t;

   vec_t vq[$];
   int   nchk  = 0;
   int   nfail = 0;

   task automatic add(input logic rst, input logic [5:0] op,
                      input logic [4:0] fn, input logic rdy,
                      input logic bc, input logic [2:0] st,
                      input logic [8:0] en, input logic [4:0] fc,
                      input logic [2:0] fl, input logic [15:0] cnt);
      vec_t v;
      v.rst = rst; v.op = op; v.fn = fn; v.rdy = rdy; v.bc = bc;
      v.st = st; v.en = en; v.fc = fc; v.fl = fl; v.cnt = cnt;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input int got, input int exp);
      nchk++;
      if (got != exp) begin
         nfail++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   function automatic logic [8:0] enables();
      return {b1.memRead, b1.memWrite, b1.irWrite, b1.pcWrite, b1.pcSrc,
              b1.regWrite, b1.memToReg, b1.aluSrcB, b1.ALUOp};
   endfunction

   initial begin
      logic [35:0] got;
      logic [35:0] exp;
      int          n;

      reset = 1'b1; opcode = '0; funct = '0;
      mem_ready = 1'b0; branch_cond = 1'b0;
      repeat (2) @(negedge clk);

      // reset held in FETCH: irWrite/pcWrite gated off
      add(1, 0, 4, 1, 0, 0, E_FW, 0, 3'b000, 0);
      // R-type funct 4
      add(0, 0, 4, 1, 0, 0, E_FR, 0, 3'b000, 0);
      add(0, 0, 4, 1, 0, 1, E0,   0, 3'b000, 0);
      add(0, 0, 4, 1, 0, 2, E_R,  4, 3'b000, 0);
      add(0, 0, 4, 1, 0, 4, E_WB, 0, 3'b000, 0);
      // lw, memory stalls 3 cycles
      add(0, 2, 0, 1, 0, 0, E_FR, 0, 3'b000, 1);
      add(0, 2, 0, 1, 0, 1, E0,   0, 3'b000, 1);
      add(0, 2, 0, 0, 0, 2, E_LS, 0, 3'b000, 1);
      for (int i = 0; i < 3; i++)
         add(0, 2, 0, 0, 0, 3, E_MR, 0, 3'b000, 1);
      add(0, 2, 0, 1, 0, 3, E_MR, 0, 3'b000, 1);
      add(0, 2, 0, 1, 0, 4, E_WL, 0, 3'b000, 1);
      // branch taken, then not taken
      add(0, 4, 0, 1, 1, 0, E_FR, 0, 3'b000, 2);
      add(0, 4, 0, 1, 1, 1, E0,   0, 3'b000, 2);
      add(0, 4, 0, 1, 1, 2, E_BT, 0, 3'b000, 2);
      add(0, 4, 0, 1, 0, 0, E_FR, 0, 3'b000, 3);
      add(0, 4, 0, 1, 0, 1, E0,   0, 3'b000, 3);
      add(0, 4, 0, 1, 0, 2, E_BN, 0, 3'b000, 3);
      // immediate funct 7
      add(0, 1, 7, 1, 0, 0, E_FR, 0, 3'b000, 4);
      add(0, 1, 7, 1, 0, 1, E0,   0, 3'b000, 4);
      add(0, 1, 7, 1, 0, 2, E_I,  7, 3'b000, 4);
      add(0, 1, 7, 1, 0, 4, E_WB, 0, 3'b000, 4);
      // sw, memory ready at once
      add(0, 3, 0, 1, 0, 0, E_FR, 0, 3'b000, 5);
      add(0, 3, 0, 1, 0, 1, E0,   0, 3'b000, 5);
      add(0, 3, 0, 1, 0, 2, E_LS, 0, 3'b000, 5);
      add(0, 3, 0, 1, 0, 3, E_MW, 0, 3'b000, 5);
      // sw aborted by reset in MEM
      add(0, 3, 0, 1, 0, 0, E_FR, 0, 3'b000, 6);
      add(0, 3, 0, 1, 0, 1, E0,   0, 3'b000, 6);
      add(0, 3, 0, 0, 0, 2, E_LS, 0, 3'b000, 6);
      add(0, 3, 0, 0, 0, 3, E_MW, 0, 3'b000, 6);
      add(1, 3, 0, 0, 0, 3, E0,   0, 3'b000, 6);
      // lw whose data arrives exactly as the wait count hits 15
      add(0, 2, 0, 1, 0, 0, E_FR, 0, 3'b000, 0);
      add(0, 2, 0, 1, 0, 1, E0,   0, 3'b000, 0);
      add(0, 2, 0, 0, 0, 2, E_LS, 0, 3'b000, 0);
      for (int i = 0; i < 15; i++)
         add(0, 2, 0, 0, 0, 3, E_MR, 0, 3'b000, 0);
      add(0, 2, 0, 1, 0, 3, E_MR, 0, 3'b000, 0);
      add(0, 2, 0, 1, 0, 4, E_WL, 0, 3'b000, 0);
      // FETCH timeout: 16 cycles with mem_ready low, then HALT/fault
      for (int i = 0; i < 16; i++)
         add(0, 0, 0, 0, 0, 0, E_FW, 0, 3'b000, 1);
      add(0, 0, 0, 0, 0, 5, E0, 0, 3'b110, 1);
      for (int i = 0; i < 3; i++)
         add(0, 0, 0, 1, 0, 5, E0, 0, 3'b110, 1);
      add(1, 0, 0, 1, 0, 5, E0, 0, 3'b110, 1);
      // R-type then illegal opcode 9
      add(0, 0, 4, 1, 0, 0, E_FR, 0, 3'b000, 0);
      add(0, 0, 4, 1, 0, 1, E0,   0, 3'b000, 0);
      add(0, 0, 4, 1, 0, 2, E_R,  4, 3'b000, 0);
      add(0, 0, 4, 1, 0, 4, E_WB, 0, 3'b000, 0);
      add(0, 9, 0, 1, 0, 0, E_FR, 0, 3'b000, 1);
      add(0, 9, 0, 1, 0, 1, E0,   0, 3'b000, 1);
      add(0, 9, 0, 1, 0, 5, E0,   0, 3'b101, 1);
      add(0, 9, 0, 1, 0, 5, E0,   0, 3'b101, 1);
      add(1, 5, 0, 1, 0, 5, E0,   0, 3'b101, 1);
      // halt opcode
      add(0, 5, 0, 1, 0, 0, E_FR, 0, 3'b000, 0);
      add(0, 5, 0, 1, 0, 1, E0,   0, 3'b000, 0);
      add(0, 5, 0, 1, 0, 5, E0,   0, 3'b100, 0);

      foreach (vq[i]) begin
         reset       = vq[i].rst;
         opcode      = vq[i].op;
         funct       = vq[i].fn;
         mem_ready   = vq[i].rdy;
         branch_cond = vq[i].bc;
         #1;
         got = {b1.state, enables(), b1.funcCode,
                b1.halted, b1.fault, b1.illegal, b1.instCount};
         exp = {vq[i].st, vq[i].en, vq[i].fc, vq[i].fl, vq[i].cnt};
         nchk++;
         if (got !== exp) begin
            nfail++;
            $display("FAIL vec%0d got st=%0d en=%b fc=%0d hfi=%b cnt=%0d exp st=%0d en=%b fc=%0d hfi=%b cnt=%0d",
                     i, got[35:33], got[32:24], got[23:19], got[18:16], got[15:0],
                     exp[35:33], exp[32:24], exp[23:19], exp[18:16], exp[15:0]);
         end
         @(negedge clk);
      end

      // CNT_W = 2: five R-types wrap 1,2,3,0,1
      reset = 1'b1; opcode = 6'd0; funct = 5'd4;
      mem_ready = 1'b1; branch_cond = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("wrap_reset", int'(b2.instCount), 0);
      for (int k = 1; k <= 5; k++) begin
         repeat (4) @(negedge clk);
         #1;
         check($sformatf("wrap_r%0d", k), int'(b2.instCount), k % 4);
         check($sformatf("wrap_st%0d", k), int'(b2.state), 0);
      end

      // lw whose memory never answers: 16 MEM cycles then HALT/fault
      opcode = 6'd2;
      repeat (2) @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      n = 0;
      while (b1.state == 3'd3 && n < 40) begin
         n++;
         @(negedge clk);
         #1;
      end
      check("memtmo_cycles", n, 16);
      check("memtmo_state", int'(b1.state), 5);
      check("memtmo_fault", int'(b1.fault), 1);
      check("memtmo_memread", int'(b1.memRead), 0);
      check("memtmo_regwrite", int'(b1.regWrite), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
